// File: rtl/fast_square_sweep_controller_pkg.sv
// -----------------------------------------------------------------------------
// fast_square_sweep_controller_pkg
//
// Shared definitions for the fast-square sweep controller:
//   - state_e      : FSM state encoding (values are visible on the debug port,
//                    so they are fixed and must not be re-ordered)
//   - debug layout : bit positions of the 4-bit debug word
//   - tick_max3    : helper used to size the shared tick down-counter
//   - pack_debug   : builds the debug word from its fields
// -----------------------------------------------------------------------------
package fast_square_sweep_controller_pkg;

  // State encoding. The numeric values appear on debug[2:0] and are used by
  // bring-up scripts, so each value is pinned explicitly.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SWEEP_RESET = 3'd1,
    ST_GUARD       = 3'd2,
    ST_WAIT_LOCK   = 3'd3,
    ST_RECORD      = 3'd4,
    ST_STEP        = 3'd5
  } state_e;

  // debug = {pll_locked_sync, state[2:0]}
  localparam int DEBUG_W        = 4;
  localparam int DEBUG_LOCK_BIT = 3;
  localparam int DEBUG_STATE_LSB = 0;
  localparam int DEBUG_STATE_W  = 3;

  // Largest of the three tick parameters; evaluated at elaboration time to
  // size the one counter shared by all timed states.
  function automatic int tick_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Assemble the debug word in one place so the field layout is only
  // described once.
  function automatic logic [DEBUG_W-1:0] pack_debug(input logic   lock_sync,
                                                    input state_e st);
    logic [DEBUG_W-1:0] w;
    w = '0;
    w[DEBUG_LOCK_BIT] = lock_sync;
    w[DEBUG_STATE_LSB +: DEBUG_STATE_W] = st;
    return w;
  endfunction

endpackage : fast_square_sweep_controller_pkg

// File: rtl/fast_square_sweep_controller_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchronizer for a single asynchronous level signal. Used for the
// daughterboard pll_locked pin. Both flops reset to 0 so that "not locked"
// is reported until a real lock level has crossed into the clock domain.
//
// Ports:
//   clk    in  : destination clock
//   rst_n  in  : asynchronous active-low reset
//   d_i    in  : asynchronous input level
//   q_o    out : synchronized level, two clock cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // that every flop samples the value from before the clock edge; with
  // blocking assignments meta_q would pass straight through to sync_q and
  // the synchronizer would collapse to a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/fast_square_sweep_controller.sv
// -----------------------------------------------------------------------------
// fast_square_sweep_controller
//
// Steps an external synthesizer through NUM_FREQ_STEPS frequencies with two
// FX2 strobe lines, waits for PLL lock at each step and then opens a fixed
// RECORD_TICKS record window for the fast-square receiver. It also tells the
// receiver when to reset and when to advance to its next frequency bin.
//
// Sweep sequence:
//   IDLE -> SWEEP_RESET -> GUARD -> WAIT_LOCK -> RECORD -+-> STEP -> GUARD ...
//                ^                                      |
//                +------------- last step --------------+
//
// Parameters:
//   NUM_FREQ_STEPS : frequencies per sweep (>= 2)
//   RECORD_TICKS   : cycles per record window (>= 1)
//   PULSE_TICKS    : width of freq_step_out / freq_step_reset_out (>= 1)
//   GUARD_TICKS    : settle cycles after each pulse before lock is sampled (>= 1)
//
// Ports:
//   clock               in  : system clock (64 MHz)
//   reset               in  : asynchronous active-low reset
//   pll_locked          in  : asynchronous lock indicator from daughterboard
//   freq_step_reset_out out : returns synthesizer to the first frequency
//   freq_step_out       out : advances synthesizer by one frequency
//   rx_reset            out : holds the receiver in reset
//   rx_next             out : one-cycle strobe, receiver advances its bin
//   rx_record           out : high during the record window
//   debug[3:0]          out : {pll_locked_sync, state[2:0]}
//
// All outputs are registers decoded from the state/counter registers of the
// previous cycle, so every output lags the state register by one clock.
// -----------------------------------------------------------------------------
module fast_square_sweep_controller
  import fast_square_sweep_controller_pkg::*;
#(
  parameter int NUM_FREQ_STEPS = 34,
  parameter int RECORD_TICKS   = 35000,
  parameter int PULSE_TICKS    = 64,
  parameter int GUARD_TICKS    = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pll_locked,
  output logic         freq_step_reset_out,
  output logic         freq_step_out,
  output logic         rx_reset,
  output logic         rx_next,
  output logic         rx_record,
  output logic [3:0]   debug
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int CNT_W  = $clog2(tick_max3(RECORD_TICKS, PULSE_TICKS,
                                           GUARD_TICKS)) + 1;
  localparam int SIDX_W = $clog2(NUM_FREQ_STEPS);

  // The counter is loaded with (ticks - 1) on entry to a timed state and the
  // state is left on the cycle it reads zero, giving exactly "ticks" cycles.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_TICKS - 1);
  localparam logic [CNT_W-1:0] RECORD_LOAD = CNT_W'(RECORD_TICKS - 1);
  localparam logic [SIDX_W-1:0] LAST_STEP  = SIDX_W'(NUM_FREQ_STEPS - 1);

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  logic pll_locked_sync;

  sync_2ff u_lock_sync (
    .clk   (clock),
    .rst_n (reset),
    .d_i   (pll_locked),
    .q_o   (pll_locked_sync)
  );

  // ---------------------------------------------------------------------------
  // State, shared tick counter, step index and output registers
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SIDX_W-1:0]  step_idx_q;

  logic               freq_step_reset_q;
  logic               freq_step_q;
  logic               rx_reset_q;
  logic               rx_next_q;
  logic               rx_record_q;
  logic [DEBUG_W-1:0] debug_q;

  logic cnt_done;
  assign cnt_done = (cnt_q == '0);

  // NOTE: every output register has an explicit asynchronous reset value so
  // that asserting reset drives the pins to their safe levels immediately,
  // without waiting for a clock edge; rx_reset resets high so the receiver
  // is held in reset while the controller itself is.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      step_idx_q        <= '0;
      freq_step_reset_q <= 1'b0;
      freq_step_q       <= 1'b0;
      rx_reset_q        <= 1'b1;
      rx_next_q         <= 1'b0;
      rx_record_q       <= 1'b0;
      debug_q           <= '0;
    end else begin
      // Output decode of the current state; appears one cycle later.
      freq_step_reset_q <= (state_q == ST_SWEEP_RESET);
      freq_step_q       <= (state_q == ST_STEP);
      rx_reset_q        <= (state_q == ST_IDLE) || (state_q == ST_SWEEP_RESET);
      rx_record_q       <= (state_q == ST_RECORD);
      // STEP is always entered with the counter at PULSE_LOAD, so that value
      // marks its first cycle.
      rx_next_q         <= (state_q == ST_STEP) && (cnt_q == PULSE_LOAD);
      debug_q           <= pack_debug(pll_locked_sync, state_q);

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_SWEEP_RESET;
          cnt_q   <= PULSE_LOAD;
        end

        ST_SWEEP_RESET: begin
          step_idx_q <= '0;
          if (cnt_done) begin
            state_q <= ST_GUARD;
            cnt_q   <= GUARD_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_GUARD: begin
          if (cnt_done) begin
            state_q <= ST_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // No timeout: a synthesizer that never locks parks the sweep here,
        // visible as state 3 on the debug port.
        ST_WAIT_LOCK: begin
          if (pll_locked_sync) begin
            state_q <= ST_RECORD;
            cnt_q   <= RECORD_LOAD;
          end
        end

        // Lock is deliberately not watched here: the window length is fixed
        // so that every bin integrates over the same number of samples.
        ST_RECORD: begin
          if (cnt_done) begin
            cnt_q <= PULSE_LOAD;
            if (step_idx_q == LAST_STEP) begin
              state_q <= ST_SWEEP_RESET;
            end else begin
              state_q    <= ST_STEP;
              step_idx_q <= step_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_STEP: begin
          if (cnt_done) begin
            state_q <= ST_GUARD;
            cnt_q   <= GUARD_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // Unreachable encodings (6, 7) recover through a fresh sweep.
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign freq_step_reset_out = freq_step_reset_q;
  assign freq_step_out       = freq_step_q;
  assign rx_reset            = rx_reset_q;
  assign rx_next             = rx_next_q;
  assign rx_record           = rx_record_q;
  assign debug               = debug_q;

endmodule : fast_square_sweep_controller

// File: tb/tb_fast_square_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_fast_square_sweep_controller
//
// Self-checking bench. A segment-level model predicts every output cycle of
// the N=3 instance; directed scenarios add hand-computed expectations
// (pulse position, window counts, lock latency, sweep length for N=34).
// -----------------------------------------------------------------------------
module tb_fast_square_sweep_controller;

  localparam int N = 3;
  localparam int R = 10;
  localparam int P = 4;
  localparam int G = 5;

  // State numbers as seen on debug[2:0]
  localparam int S_IDLE = 0, S_SR = 1, S_GUARD = 2, S_WAIT = 3, S_REC = 4, S_STEP = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       lock_34 = 1'b1;

  logic       frs, fso, rx_reset, rx_next, rx_record;
  logic [3:0] debug;
  logic       frs_34, fso_34, rx_reset_34, rx_next_34, rx_record_34;
  logic [3:0] debug_34;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  fast_square_sweep_controller #(
    .NUM_FREQ_STEPS(N), .RECORD_TICKS(R), .PULSE_TICKS(P), .GUARD_TICKS(G)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .freq_step_reset_out(frs), .freq_step_out(fso), .rx_reset(rx_reset),
    .rx_next(rx_next), .rx_record(rx_record), .debug(debug)
  );

  fast_square_sweep_controller #(
    .NUM_FREQ_STEPS(34), .RECORD_TICKS(R), .PULSE_TICKS(P), .GUARD_TICKS(G)
  ) dut_34 (
    .clock(clock), .reset(reset), .pll_locked(lock_34),
    .freq_step_reset_out(frs_34), .freq_step_out(fso_34), .rx_reset(rx_reset_34),
    .rx_next(rx_next_34), .rx_record(rx_record_34), .debug(debug_34)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model: a queue of per-cycle state slots filled one segment at a time.
  // The segment that follows depends only on the segment just finished,
  // the sweep position and the lock level two edges ago.
  // ---------------------------------------------------------------------------
  typedef struct { int st; bit first; } slot_t;
  slot_t sched[$];

  int  m_st;         // state during the cycle that just ended
  bit  m_first;
  int  m_step;
  bit  lk1, lk2;     // pll_locked at the previous two posedges
  bit  e_frs, e_fso, e_rxr, e_next, e_rec;
  logic [3:0] e_dbg;

  function automatic void push_seg(input int st, input int len);
    for (int i = 0; i < len; i++) sched.push_back('{st: st, first: (i == 0)});
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sched.delete();
      m_st = S_IDLE; m_first = 1'b0; m_step = 0; lk1 = 1'b0; lk2 = 1'b0;
      e_frs = 0; e_fso = 0; e_rxr = 1; e_next = 0; e_rec = 0; e_dbg = 4'h0;
    end else begin
      slot_t s;
      // Outputs this cycle reflect the state of the cycle just ended.
      e_frs  = (m_st == S_SR);
      e_fso  = (m_st == S_STEP);
      e_rxr  = (m_st == S_IDLE) || (m_st == S_SR);
      e_rec  = (m_st == S_REC);
      e_next = (m_st == S_STEP) && m_first;
      e_dbg  = {lk2, 3'(m_st)};
      if (sched.size() == 0) begin
        case (m_st)
          S_IDLE:  push_seg(S_SR, P);
          S_SR:    push_seg(S_GUARD, G);
          S_GUARD: push_seg(S_WAIT, 1);
          S_WAIT:  if (lk2) push_seg(S_REC, R); else push_seg(S_WAIT, 1);
          S_REC: begin
            if (m_step == N - 1) begin push_seg(S_SR, P); m_step = 0; end
            else begin push_seg(S_STEP, P); m_step++; end
          end
          default: push_seg(S_GUARD, G);   // after STEP
        endcase
      end
      s = sched.pop_front();
      m_st = s.st; m_first = s.first;
      lk2 = lk1; lk1 = pll_locked;
    end
  end

  // Per-cycle comparison against the model (or reset values while in reset).
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_frs", frs, 0);  check("rst_fso", fso, 0);
      check("rst_rx_reset", rx_reset, 1); check("rst_rx_next", rx_next, 0);
      check("rst_rx_record", rx_record, 0); check("rst_debug", debug, 0);
    end else begin
      check("cyc_frs", frs, e_frs);  check("cyc_fso", fso, e_fso);
      check("cyc_rx_reset", rx_reset, e_rxr); check("cyc_rx_next", rx_next, e_next);
      check("cyc_rx_record", rx_record, e_rec); check("cyc_debug", debug, e_dbg);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers (called at a negedge)
  // ---------------------------------------------------------------------------
  // Release reset and confirm freq_step_reset_out is high on samples 2..5.
  task automatic release_check(input string tag);
    logic [5:0] pat;
    #1 reset = 1'b1;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      pat[k] = frs;
    end
    check({tag, "_frs_pulse_pattern"}, pat, 6'b011110);
  endtask

  // Observe from now until the next rising freq_step_reset_out.
  task automatic measure_sweep(input string tag);
    int wins = 0, recs = 0, nexts = 0, steps = 0, run = 0, maxw = 0;
    bit p_frs = frs, p_rec = rx_record, done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clock);
      if (frs && !p_frs) done = 1;
      else begin
        if (rx_record && !p_rec) begin wins++; run = 0; end
        if (rx_record) begin recs++; run++; if (run > maxw) maxw = run; end
        if (rx_next) nexts++;
        if (fso) steps++;
      end
      p_frs = frs; p_rec = rx_record;
    end
    check({tag, "_sweep_done"}, done, 1);
    check({tag, "_windows"}, wins, 3);
    check({tag, "_record_cycles"}, recs, 30);
    check({tag, "_window_len"}, maxw, 10);
    check({tag, "_rx_next_pulses"}, nexts, 2);
    check({tag, "_step_cycles"}, steps, 8);
  endtask

  task automatic wait_record_rise(input string tag, input int budget, output int lat);
    bit p = rx_record;
    lat = 0;
    for (int c = 1; c <= budget && lat == 0; c++) begin
      @(negedge clock);
      if (rx_record && !p) lat = c;
      p = rx_record;
    end
    if (lat == 0) check({tag, "_record_rise_timeout"}, 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int lat, len, highs, nexts, wins;
    bit p, p2, seen;

    // Reset
    reset = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clock);
    check("hold_rx_reset", rx_reset, 1);
    check("hold_frs", frs, 0);
    check("hold_record", rx_record, 0);
    release_check("rel1");

    // Locked sweep: two full sweeps
    measure_sweep("sweep1");
    measure_sweep("sweep2");

    // Lock wait
    #1 reset = 1'b0; pll_locked = 1'b0;
    repeat (2) @(negedge clock);
    release_check("rel2");
    repeat (G + 2) @(negedge clock);
    highs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (rx_record) highs++;
    end
    check("lockwait_record_cycles", highs, 0);
    check("lockwait_debug_state", debug[2:0], 3);
    check("lockwait_debug_lock", debug[3], 0);
    #1 pll_locked = 1'b1;
    wait_record_rise("lockwait", 20, lat);
    check("lock_latency_le4", (lat >= 1 && lat <= 4), 1);

    // Lock glitch in RECORD (rx_record just rose: one high cycle seen)
    len = 1;
    repeat (2) begin @(negedge clock); if (rx_record) len++; end
    #1 pll_locked = 1'b0;
    repeat (2) begin @(negedge clock); if (rx_record) len++; end
    #1 pll_locked = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (rx_record) len++; else seen = 1;
    end
    check("glitch_window_len", len, 10);

    // Mid-record reset
    wait_record_rise("midrec", 200, lat);
    repeat (3) @(negedge clock);
    check("midrec_in_record", rx_record, 1);
    #1 reset = 1'b0;
    #1;
    check("midrec_record_dropped", rx_record, 0);
    check("midrec_rx_reset", rx_reset, 1);
    check("midrec_debug", debug, 0);
    @(negedge clock);
    release_check("rel3");

    // Sweep length for N=34: count between two consecutive reset pulses
    p = frs_34; seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clock);
      if (frs_34 && !p) seen = 1;
      p = frs_34;
    end
    check("n34_first_frs_seen", seen, 1);
    nexts = 0; wins = 0; seen = 0; p2 = rx_record_34;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clock);
      if (frs_34 && !p) seen = 1;
      else begin
        if (rx_next_34) nexts++;
        if (rx_record_34 && !p2) wins++;
      end
      p = frs_34; p2 = rx_record_34;
    end
    check("n34_second_frs_seen", seen, 1);
    check("n34_rx_next_pulses", nexts, 33);
    check("n34_windows", wins, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_fast_square_sweep_controller
